// File: rtl/clk_en_pkg.sv
// Shared types and parameter defaults for the Gray-counter clock-enable controller.
package clk_en_pkg;

    typedef enum logic {
        PAUSED  = 1'b0,
        RUNNING = 1'b1
    } ce_state_t;

    // Board defaults: 1 Hz count rate from a 25 MHz clock, 20 ms debounce.
    localparam int unsigned DIV_DEFAULT        = 25_000_000;
    localparam int unsigned CNT_W_DEFAULT      = 25;
    localparam int unsigned DEB_CYCLES_DEFAULT = 500_000;
    localparam int unsigned DEB_W_DEFAULT      = 19;

    // Small values so simulation exercises every path in a few hundred cycles.
    localparam int unsigned DIV_SIM        = 4;
    localparam int unsigned CNT_W_SIM      = 3;
    localparam int unsigned DEB_CYCLES_SIM = 4;
    localparam int unsigned DEB_W_SIM      = 3;

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: two-flop synchroniser, stability counter and
// rising-edge pulse generator on the accepted level.
module btn_debounce
    import clk_en_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEFAULT,
    parameter int unsigned DEB_W      = DEB_W_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic pulse
);

    logic             sync1_q;
    logic             sync2_q;
    logic             stable_q;
    logic             stable_d;
    logic             pulse_q;
    logic             pulse_d;
    logic [DEB_W-1:0] cnt_q;
    logic [DEB_W-1:0] cnt_d;

    // Count cycles of disagreement; accept the new level once the count has
    // reached DEB_CYCLES and the input still disagrees.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        if (sync2_q != stable_q) begin
            if (cnt_q == DEB_W'(DEB_CYCLES)) begin
                stable_d = sync2_q;
                cnt_d    = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        pulse_d = stable_d & ~stable_q;
    end

    // Synchroniser, accepted level, counter and registered press pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
            pulse_q  <= 1'b0;
        end else begin
            sync1_q  <= btn_in;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            pulse_q  <= pulse_d;
        end
    end

    assign pulse = pulse_q;

endmodule

// File: rtl/clk_en_ctrl.sv
// Clock-enable controller for the 4-bit Gray counter: prescaler plus a
// run/pause FSM driven by two debounced push buttons.
module clk_en_ctrl
    import clk_en_pkg::*;
#(
    parameter int unsigned DIV        = DIV_DEFAULT,
    parameter int unsigned CNT_W      = CNT_W_DEFAULT,
    parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEFAULT,
    parameter int unsigned DEB_W      = DEB_W_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_run,
    input  logic btn_step,
    output logic clk_en,
    output logic running
);

    logic             run_p;
    logic             step_p;
    ce_state_t        state_q;
    ce_state_t        state_d;
    logic [CNT_W-1:0] presc_q;
    logic [CNT_W-1:0] presc_d;
    logic             clk_en_q;
    logic             clk_en_d;
    logic             running_q;
    logic             running_d;

    btn_debounce #(
        .DEB_CYCLES (DEB_CYCLES),
        .DEB_W      (DEB_W)
    ) u_deb_run (
        .clk    (clk),
        .rst    (rst),
        .btn_in (btn_run),
        .pulse  (run_p)
    );

    btn_debounce #(
        .DEB_CYCLES (DEB_CYCLES),
        .DEB_W      (DEB_W)
    ) u_deb_step (
        .clk    (clk),
        .rst    (rst),
        .btn_in (btn_step),
        .pulse  (step_p)
    );

    // Next state: run_p has priority over both a prescaler wrap and step_p.
    always_comb begin
        state_d  = state_q;
        presc_d  = '0;
        clk_en_d = 1'b0;
        unique case (state_q)
            RUNNING: begin
                if (run_p) begin
                    state_d = PAUSED;
                end else if (presc_q == CNT_W'(DIV - 1)) begin
                    clk_en_d = 1'b1;
                end else begin
                    presc_d = presc_q + 1'b1;
                end
            end
            PAUSED: begin
                if (run_p) begin
                    state_d = RUNNING;
                end else begin
                    clk_en_d = step_p;
                end
            end
            default: begin
                state_d = RUNNING;
            end
        endcase
        running_d = (state_d == RUNNING);
    end

    // FSM state, prescaler and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= RUNNING;
            presc_q   <= '0;
            clk_en_q  <= 1'b0;
            running_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            clk_en_q  <= clk_en_d;
            running_q <= running_d;
        end
    end

    assign clk_en  = clk_en_q;
    assign running = running_q;

endmodule

// File: tb/tb_clk_en_ctrl.sv
// Directed bench for clk_en_ctrl with DIV=4, DEB_CYCLES=4. Button levels and
// expected outputs are tabulated per edge number after reset release.
module tb_clk_en_ctrl;
    import clk_en_pkg::*;

    logic clk;
    logic rst;
    logic btn_run;
    logic btn_step;
    logic clk_en;
    logic running;

    int unsigned n_checks = 0;
    int unsigned n_bad    = 0;

    // Edges where clk_en must be high (hand-derived timeline, edges 1..199).
    int en_edges[18] = '{4, 8, 12, 16, 20, 51, 55, 59, 63, 87, 102, 117,
                         156, 160, 164, 168, 172, 176};
    // Edges where running toggles (starts at 1).
    int run_tog[6]   = '{24, 47, 67, 152, 177, 197};

    clk_en_ctrl #(
        .DIV        (DIV_SIM),
        .CNT_W      (CNT_W_SIM),
        .DEB_CYCLES (DEB_CYCLES_SIM),
        .DEB_W      (DEB_W_SIM)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_run  (btn_run),
        .btn_step (btn_step),
        .clk_en   (clk_en),
        .running  (running)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // btn_run raw level sampled at edge e.
    function automatic logic run_in(input int e);
        if (e >= 17 && e <= 26)   return 1'b1;
        if (e >= 40 && e <= 49)   return 1'b1;
        if (e >= 60 && e <= 69)   return 1'b1;
        if (e >= 125 && e <= 144) return (((e - 125) / 2) % 2) == 0;
        if (e >= 145 && e <= 160) return 1'b1;
        if (e >= 170 && e <= 179) return 1'b1;
        if (e >= 190 && e <= 199) return 1'b1;
        return 1'b0;
    endfunction

    // btn_step raw level sampled at edge e.
    function automatic logic step_in(input int e);
        if (e >= 80 && e <= 85)   return 1'b1;
        if (e >= 95 && e <= 100)  return 1'b1;
        if (e >= 110 && e <= 115) return 1'b1;
        if (e >= 154 && e <= 159) return 1'b1;
        if (e >= 190 && e <= 199) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic exp_en(input int e);
        foreach (en_edges[i]) if (en_edges[i] == e) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic exp_run(input int e);
        int c = 0;
        foreach (run_tog[i]) if (run_tog[i] <= e) c++;
        return (c % 2) == 0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst      = 1'b0;
        btn_run  = 1'b0;
        btn_step = 1'b0;
        tick();
        tick();
        check("rst_clk_en", {31'd0, clk_en}, 32'd0);
        check("rst_running", {31'd0, running}, 32'd1);
        rst = 1'b1;

        // Free run, pause/resume, stepping, bounce, collisions.
        for (int e = 1; e <= 199; e++) begin
            btn_run  = run_in(e);
            btn_step = step_in(e);
            tick();
            check($sformatf("clk_en@%0d", e), {31'd0, clk_en}, {31'd0, exp_en(e)});
            check($sformatf("running@%0d", e), {31'd0, running}, {31'd0, exp_run(e)});
        end

        // Reset with prescaler at 2, held for three edges.
        btn_run  = 1'b0;
        btn_step = 1'b0;
        rst      = 1'b0;
        #1;
        check("mid_rst_clk_en", {31'd0, clk_en}, 32'd0);
        check("mid_rst_running", {31'd0, running}, 32'd1);
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("in_rst_clk_en%0d", k), {31'd0, clk_en}, 32'd0);
            check($sformatf("in_rst_running%0d", k), {31'd0, running}, 32'd1);
        end
        rst = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            check($sformatf("post_rst_clk_en@%0d", k), {31'd0, clk_en},
                  (k % 4 == 0) ? 32'd1 : 32'd0);
            check($sformatf("post_rst_running@%0d", k), {31'd0, running}, 32'd1);
        end

        // Pulse in flight is killed asynchronously by reset.
        rst = 1'b0;
        #1;
        check("kill_clk_en", {31'd0, clk_en}, 32'd0);
        check("kill_running", {31'd0, running}, 32'd1);
        tick();
        rst = 1'b1;

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule

// File: doc/clk_en_ctrl.md
# clk_en_ctrl

Clock-enable controller that sits directly upstream of the 4-bit Gray counter and drives its `clk_en` input. It divides the board clock down to a visible counting rate and lets the user run, pause and single-step the counter from two push buttons. It contains a prescaler, a two-state run/pause FSM and two debounced button-edge detectors.

## Interface

- `DIV`, default 25_000_000: prescaler period in `clk` cycles; legal range 1..2^CNT_W−1.
- `CNT_W`, default 25: prescaler counter width; must satisfy 2^CNT_W > DIV.
- `DEB_CYCLES`, default 500_000: consecutive stable cycles required before a button level is accepted; minimum 1.
- `DEB_W`, default 19: debounce counter width; must satisfy 2^DEB_W > DEB_CYCLES.

- `clk` in 1: single system clock; all state is on its rising edge.
- `rst` in 1: asynchronous, active-low reset; deassertion is assumed synchronous to `clk` upstream.
- `btn_run` in 1: raw, asynchronous push button, active-high; each press toggles run/pause.
- `btn_step` in 1: raw, asynchronous push button, active-high; each press gives one step while paused.
- `clk_en` out 1: registered one-cycle enable pulse to the Gray counter.
- `running` out 1: registered; 1 in RUNNING, 0 in PAUSED.

## Operation

- **Reset (`rst`=0):**
  - FSM = RUNNING; prescaler = 0; `clk_en` = 0; `running` = 1.
  - Debouncer sync flops, stable level and counters = 0.
- **Debounce (per button):**
  - Two-flop synchroniser on the raw input.
  - The counter counts cycles where the synchronised value differs from the accepted level. It clears on any cycle where they match.
  - When the counter reaches DEB_CYCLES, the accepted level takes the new value and the counter clears.
  - A rising edge of the accepted level produces a one-cycle pulse (`run_p`, `step_p`). Releases produce nothing.
- **FSM states:** RUNNING, PAUSED.
- **RUNNING:**
  - The prescaler increments every cycle.
  - When it equals DIV−1 it wraps to 0 and `clk_en` is registered 1 for the next cycle; otherwise `clk_en` is 0.
  - DIV=1 gives `clk_en` constantly 1.
- **RUNNING + `run_p`:**
  - Go to PAUSED and clear the prescaler.
  - `clk_en` is 0 next cycle, even if the prescaler would have wrapped that same cycle. The pause wins.
- **PAUSED:**
  - The prescaler holds at 0.
  - A `step_p` registers `clk_en`=1 for exactly one cycle; the FSM stays PAUSED.
- **PAUSED + `run_p`:** go to RUNNING with the prescaler at 0; the first pulse comes DIV cycles later.
- **`step_p` in RUNNING:** ignored, not queued.
- **`run_p` and `step_p` in the same cycle:** `run_p` is acted on; `step_p` is discarded in either state.
- **Reset mid-operation:** everything returns to the reset values immediately, and any `clk_en` pulse in flight is killed.

## Timing

- Cycle numbering: cycle n = the n-th rising edge after `rst` deasserts.
- **`clk_en` while RUNNING:** exactly 1 of every DIV cycles. It is first high after edge DIV, i.e. it is sampled high by the downstream counter at edge DIV+1.
- **Button latency:** the raw input stable high from edge t gives a debounce pulse after edge t+2+DEB_CYCLES. The resulting `clk_en` (step) or `running` change is visible one edge later, giving DEB_CYCLES+3 cycles total.
- **Bounce:** any glitch shorter than DEB_CYCLES cycles yields no pulse.
- **Outputs:** all outputs are flop outputs with no combinational path from inputs.

## Structure

- Package `clk_en_pkg`:
  - state enum `ce_state_t` {PAUSED, RUNNING};
  - default constants for DIV/DEB_CYCLES;
  - simulation-friendly overrides (DIV=4, DEB_CYCLES=4).
- Sub-module `btn_debounce` (params DEB_CYCLES, DEB_W; ports clk, rst, btn_in, pulse), instantiated twice.
- The top level holds the prescaler, the FSM and the output registers.

## Test plan

All scenarios use DIV=4, DEB_CYCLES=4.

1. **Free run:** release reset, no buttons. `running`=1 throughout; `clk_en` is high after edges 4, 8, 12, 16 and low otherwise.
2. **Pause/resume:** clean `btn_run` press held 10 cycles.
   - `running` falls 7 cycles after the press starts; no `clk_en` while paused.
   - A second press gives `running`=1, and the first `clk_en` comes 4 cycles after the `running` rise.
3. **Single step:** while paused, press `btn_step` three times with clean pulses. Exactly three one-cycle `clk_en` pulses, each 7 cycles after its press; `running` stays 0.
4. **Bounce rejection:** `btn_run` toggling every 2 cycles for 20 cycles, then stable high. One `run_p` only, 7 cycles after the final stable edge; no `running` change during the bounce.
5. **Collision cases:**
   - `run_p` and `step_p` in the same cycle while paused: `running`→1 with no step pulse.
   - `run_p` coinciding with a prescaler wrap: `clk_en` stays 0.
6. **Reset mid-operation:** assert `rst`=0 for 3 cycles during RUNNING with the prescaler at 2. `clk_en`=0 and `running`=1 immediately; after release, the next `clk_en` comes after edge 4.
